// File: rtl/flash_prog.sv
// SPI NOR page-program engine: WREN, PAGE PROGRAM (1..256 bytes), then RDSR polling until WIP clears.
// Define FLASH_PROG_ERASE_EN to add a 4 KiB sector-erase request input.
module flash_prog #(
    parameter int ADDR_NBIT = 24,
    parameter int CLK_DIV   = 2,
    parameter int CS_GAP    = 4,
    parameter int POLL_MAX  = 65535
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic                 wr,
    input  logic [ADDR_NBIT-1:0] waddr,
    input  logic [8:0]           wlen,
    input  logic [7:0]           wdata,
    input  logic                 wdv,
`ifdef FLASH_PROG_ERASE_EN
    input  logic                 erase,
`endif
    output logic                 wready,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 sclk,
    output logic                 cs,
    output logic                 sdo,
    input  logic                 sdi,
    output logic                 wp,
    output logic                 hold
);

    localparam int SH_W = 8 + ADDR_NBIT;
    localparam int PW   = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;
    localparam logic [7:0]  DIV_RL  = 8'(CLK_DIV - 1);
    localparam logic [7:0]  GAP_RL  = 8'(CS_GAP - 1);
    localparam logic [5:0]  NB_ADDR = 6'(SH_W);
    localparam logic [PW:0] PMAX    = POLL_MAX[PW:0];

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_START, S_SHIFT, S_DREQ, S_GAP, S_EVAL} state_t;
    typedef enum logic [2:0] {F_WREN, F_PP, F_DATA, F_SE, F_RDSR, F_POLL} frame_t;

    state_t              state_q;
    frame_t              frame_q, after_wren_d;
    logic [ADDR_NBIT-1:0] addr_q;
    logic [8:0]          cnt_q;
    logic [SH_W-1:0]     sh_q, sh_d;
    logic [5:0]          bits_q, bits_d;
    logic [7:0]          div_q, gap_q, rx_q;
    logic [PW-1:0]       poll_q;
    logic [PW:0]         poll_d;
    logic                len_bad_d, reject_d;
    logic                wready_q, busy_q, done_q, err_q, sclk_q, cs_q, sdo_q;
`ifdef FLASH_PROG_ERASE_EN
    logic                er_q;
`endif

    always_comb begin
        poll_d    = {1'b0, poll_q} + {{PW{1'b0}}, 1'b1};
        len_bad_d = (cnt_q == 9'd0) || (cnt_q > 9'd256) ||
                    (({2'b00, addr_q[7:0]} + {1'b0, cnt_q}) > 10'd256);
`ifdef FLASH_PROG_ERASE_EN
        reject_d     = len_bad_d && !er_q;
        after_wren_d = er_q ? F_SE : F_PP;
`else
        reject_d     = len_bad_d;
        after_wren_d = F_PP;
`endif
        case (frame_q)
            F_PP: begin
                sh_d   = {8'h02, addr_q};
                bits_d = NB_ADDR;
            end
            F_SE: begin
                sh_d   = {8'h20, addr_q[ADDR_NBIT-1:12], 12'h000};
                bits_d = NB_ADDR;
            end
            F_RDSR: begin
                sh_d   = {8'h05, {ADDR_NBIT{1'b0}}};
                bits_d = 6'd16;
            end
            default: begin
                sh_d   = {8'h06, {ADDR_NBIT{1'b0}}};
                bits_d = 6'd8;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            frame_q  <= F_WREN;
            addr_q   <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
            bits_q   <= '0;
            div_q    <= '0;
            gap_q    <= '0;
            rx_q     <= '0;
            poll_q   <= '0;
            wready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sclk_q   <= 1'b0;
            cs_q     <= 1'b0;
            sdo_q    <= 1'b0;
`ifdef FLASH_PROG_ERASE_EN
            er_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
`ifdef FLASH_PROG_ERASE_EN
                    if (erase) begin
                        er_q    <= 1'b1;
                        addr_q  <= waddr;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end else if (wr) begin
                        er_q    <= 1'b0;
                        addr_q  <= waddr;
                        cnt_q   <= wlen;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
`else
                    if (wr) begin
                        addr_q  <= waddr;
                        cnt_q   <= wlen;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
`endif
                end
                S_CHECK: begin
                    poll_q  <= '0;
                    frame_q <= F_WREN;
                    if (reject_d) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    cs_q    <= 1'b1;
                    sclk_q  <= 1'b0;
                    sh_q    <= sh_d;
                    sdo_q   <= sh_d[SH_W-1];
                    bits_q  <= bits_d;
                    div_q   <= DIV_RL;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (div_q != 8'd0) begin
                        div_q <= div_q - 8'd1;
                    end else begin
                        div_q  <= DIV_RL;
                        sclk_q <= ~sclk_q;
                        // Rising edge samples sdi; falling edge advances sdo or closes the frame.
                        if (!sclk_q) begin
                            rx_q <= {rx_q[6:0], sdi};
                        end else if (bits_q != 6'd1) begin
                            bits_q <= bits_q - 6'd1;
                            sh_q   <= sh_q << 1;
                            sdo_q  <= sh_q[SH_W-2];
                        end else if (frame_q == F_PP || (frame_q == F_DATA && cnt_q != 9'd0)) begin
                            frame_q  <= F_DATA;
                            wready_q <= 1'b1;
                            state_q  <= S_DREQ;
                        end else begin
                            cs_q    <= 1'b0;
                            sdo_q   <= 1'b0;
                            gap_q   <= GAP_RL;
                            state_q <= S_GAP;
                            case (frame_q)
                                F_WREN:  frame_q <= after_wren_d;
                                F_RDSR:  frame_q <= F_POLL;
                                default: frame_q <= F_RDSR;
                            endcase
                        end
                    end
                end
                S_DREQ: begin
                    if (wdv) begin
                        wready_q <= 1'b0;
                        sh_q     <= {wdata, {ADDR_NBIT{1'b0}}};
                        sdo_q    <= wdata[7];
                        bits_q   <= 6'd8;
                        div_q    <= DIV_RL;
                        cnt_q    <= cnt_q - 9'd1;
                        state_q  <= S_SHIFT;
                    end
                end
                S_GAP: begin
                    if (gap_q != 8'd0) gap_q <= gap_q - 8'd1;
                    else state_q <= (frame_q == F_POLL) ? S_EVAL : S_START;
                end
                S_EVAL: begin
                    if (!rx_q[0]) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (poll_d == PMAX) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        poll_q  <= poll_d[PW-1:0];
                        frame_q <= F_RDSR;
                        state_q <= S_START;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wready = wready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign sclk   = sclk_q;
    assign cs     = cs_q;
    assign sdo    = sdo_q;
    assign wp     = 1'b0;
    assign hold   = 1'b0;

endmodule

// File: tb/tb_flash_prog.sv
// Scoreboard bench for flash_prog: a SPI flash model checks MOSI bytes against a queue of
// expected bytes, and a monitor checks done/err pulses against a queue of expected events.
module tb_flash_prog;

    localparam logic [1:0] EV_DONE = 2'b10;
    localparam logic [1:0] EV_ERR  = 2'b01;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic        wr = 1'b0;
    logic [23:0] waddr = '0;
    logic [8:0]  wlen = '0;
    logic [7:0]  wdata = '0;
    logic        wdv = 1'b0;
    logic        sdi = 1'b0;
`ifdef FLASH_PROG_ERASE_EN
    logic        erase = 1'b0;
`endif
    logic wready, busy, done, err, sclk, cs, sdo, wp, hold;

    flash_prog #(.ADDR_NBIT(24), .CLK_DIV(2), .CS_GAP(4), .POLL_MAX(3)) dut (
        .mclk(mclk), .rst_n(rst_n), .wr(wr), .waddr(waddr), .wlen(wlen),
        .wdata(wdata), .wdv(wdv),
`ifdef FLASH_PROG_ERASE_EN
        .erase(erase),
`endif
        .wready(wready), .busy(busy), .done(done), .err(err), .sclk(sclk),
        .cs(cs), .sdo(sdo), .sdi(sdi), .wp(wp), .hold(hold)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;
    logic [7:0] expBytes[$];
    logic [1:0] expEvents[$];
    logic [7:0] statusQ[$];
    logic [7:0] srcQ[$];

    int         fbits = 0;
    logic [7:0] fsr = '0, fcmd = '0, fstat = '0, popped;
    logic [1:0] ev;
    logic       abortFrame = 1'b1;
    int         csCount = 0, rdsrCount = 0, wreadyCount = 0;
    int         sent = 0, stallAt = -1, stallLeft = 0;
    logic       pending = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic failNote(input string name, input logic [31:0] actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s: actual=%0h expected=none", name, actual);
    endtask

    // Flash model: collects MOSI bytes on sclk rising edges and serves RDSR status bytes.
    always @(posedge cs) begin
        fbits = 0;
        fcmd = '0;
        abortFrame = 1'b0;
        csCount++;
    end

    always @(posedge sclk) begin
        if (cs) begin
            fsr = {fsr[6:0], sdo};
            fbits++;
            if (fbits % 8 == 0) begin
                if (fbits == 8) fcmd = fsr;
                if (fbits == 8 || fcmd != 8'h05) begin
                    if (expBytes.size() == 0) failNote("unexpected_spi_byte", 32'(fsr));
                    else begin
                        popped = expBytes.pop_front();
                        checkOutput("spi_byte", 32'(fsr), 32'(popped));
                    end
                end
                if (fbits == 8 && fsr == 8'h05) begin
                    rdsrCount++;
                    fstat = (statusQ.size() > 0) ? statusQ.pop_front() : 8'h00;
                end
            end
        end
    end

    always @(negedge sclk) begin
        if (cs && fcmd == 8'h05 && fbits >= 8 && fbits < 16) sdi = fstat[3'(15 - fbits)];
    end

    always @(negedge cs) begin
        sdi = 1'b0;
        if (!abortFrame) checkOutput("frame_whole_bytes", 32'(fbits % 8), 32'd0);
    end

    always @(negedge mclk) begin
        if (rst_n === 1'b1 && (done || err)) begin
            if (expEvents.size() == 0) failNote("unexpected_done_err", 32'({done, err}));
            else begin
                ev = expEvents.pop_front();
                checkOutput("done_err_event", 32'({done, err}), 32'(ev));
            end
        end
        if (wready) wreadyCount++;
    end

    // Data source: presents bytes from srcQ, optionally withholding one byte while wready is up.
    always @(negedge mclk) begin
        if (pending && rst_n) begin
            srcQ.delete(0);
            sent++;
        end
        if (sent == stallAt && stallLeft > 0 && srcQ.size() > 0) begin
            wdv = 1'b0;
            if (wready) begin
                stallLeft--;
                checkOutput("stall_sclk_low", 32'(sclk), 32'd0);
                checkOutput("stall_cs_high", 32'(cs), 32'd1);
            end
        end else if (srcQ.size() > 0) begin
            wdv = 1'b1;
            wdata = srcQ[0];
        end else begin
            wdv = 1'b0;
            wdata = '0;
        end
        pending = wready && wdv;
    end

    task automatic applyStimulus(input logic [23:0] a, input logic [8:0] len);
        @(negedge mclk);
        waddr = a;
        wlen = len;
        wr = 1'b1;
        @(negedge mclk);
        wr = 1'b0;
        checkOutput("busy_after_wr", 32'(busy), 32'd1);
    endtask

    task automatic waitFinish(input string name);
        int n = 0;
        while (!(done || err) && n < 5000) begin
            @(negedge mclk);
            n++;
        end
        if (!(done || err)) failNote({name, "_timeout"}, 32'(n));
    endtask

    task automatic endTest(input string name);
        repeat (40) @(negedge mclk);
        checkOutput({name, "_bytes_left"}, 32'(expBytes.size()), 32'd0);
        checkOutput({name, "_events_left"}, 32'(expEvents.size()), 32'd0);
        checkOutput({name, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: actual=running expected=finished");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int n;
        int c0;
        int r0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge mclk);
        checkOutput("rst_wready", 32'(wready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_sclk", 32'(sclk), 32'd0);
        checkOutput("rst_cs", 32'(cs), 32'd0);
        checkOutput("rst_sdo", 32'(sdo), 32'd0);
        checkOutput("rst_wp_hold", 32'({wp, hold}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge mclk);

        $display("[TB] program 4 bytes, status 03 03 00");
        expBytes = '{8'h06, 8'h02, 8'h01, 8'h23, 8'h00, 8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h05, 8'h05, 8'h05};
        statusQ = '{8'h03, 8'h03, 8'h00};
        srcQ = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
        sent = 0;
        expEvents = '{EV_DONE};
        applyStimulus(24'h012300, 9'd4);
        waitFinish("prog4");
        checkOutput("prog4_bytes_consumed", 32'(sent), 32'd4);
        endTest("prog4");

        $display("[TB] reject wlen=0 and page crossing");
        c0 = csCount;
        expEvents = '{EV_ERR};
        applyStimulus(24'h000000, 9'd0);
        @(negedge mclk);
        checkOutput("len0_err_pulse", 32'(err), 32'd1);
        checkOutput("len0_busy_low", 32'(busy), 32'd0);
        endTest("len0");
        expEvents = '{EV_ERR};
        applyStimulus(24'h0000F0, 9'd32);
        @(negedge mclk);
        checkOutput("cross_err_pulse", 32'(err), 32'd1);
        endTest("cross");
        checkOutput("reject_no_cs", 32'(csCount - c0), 32'd0);

        $display("[TB] program 3 bytes with a 20-cycle stall before byte 2");
        expBytes = '{8'h06, 8'h02, 8'h0A, 8'h0B, 8'h0C, 8'h11, 8'h22, 8'h33, 8'h05};
        statusQ = '{8'h00};
        srcQ = '{8'h11, 8'h22, 8'h33};
        sent = 0;
        stallAt = 1;
        stallLeft = 20;
        expEvents = '{EV_DONE};
        applyStimulus(24'h0A0B0C, 9'd3);
        waitFinish("stall");
        checkOutput("stall_bytes_consumed", 32'(sent), 32'd3);
        checkOutput("stall_cycles_seen", 32'(stallLeft), 32'd0);
        stallAt = -1;
        endTest("stall");

        $display("[TB] poll timeout with status stuck at 01");
        expBytes = '{8'h06, 8'h02, 8'h00, 8'h00, 8'h10, 8'h77, 8'h05, 8'h05, 8'h05};
        statusQ = '{8'h01, 8'h01, 8'h01};
        srcQ = '{8'h77};
        sent = 0;
        r0 = rdsrCount;
        expEvents = '{EV_ERR};
        applyStimulus(24'h000010, 9'd1);
        waitFinish("poll");
        endTest("poll");
        checkOutput("poll_rdsr_frames", 32'(rdsrCount - r0), 32'd3);

        $display("[TB] reset during PP address");
        expBytes = '{8'h06, 8'h02, 8'h01};
        srcQ = '{8'hAA, 8'hBB};
        sent = 0;
        applyStimulus(24'h012300, 9'd2);
        n = 0;
        while (!(fcmd == 8'h02 && fbits >= 18) && n < 3000) begin
            @(negedge mclk);
            n++;
        end
        checkOutput("abort_reached_addr_bit", 32'(fcmd == 8'h02 && fbits >= 18), 32'd1);
        abortFrame = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_cs", 32'(cs), 32'd0);
        checkOutput("abort_sclk", 32'(sclk), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_bytes_seen", 32'(expBytes.size()), 32'd0);
        repeat (3) @(negedge mclk);
        srcQ.delete();
        statusQ.delete();
        rst_n = 1'b1;
        endTest("abort");

        $display("[TB] program after reset");
        expBytes = '{8'h06, 8'h02, 8'h00, 8'h00, 8'h00, 8'hC3, 8'h05};
        statusQ = '{8'h00};
        srcQ = '{8'hC3};
        sent = 0;
        expEvents = '{EV_DONE};
        applyStimulus(24'h000000, 9'd1);
        waitFinish("after_rst");
        checkOutput("after_rst_bytes_consumed", 32'(sent), 32'd1);
        endTest("after_rst");

`ifdef FLASH_PROG_ERASE_EN
        $display("[TB] sector erase");
        expBytes = '{8'h06, 8'h20, 8'h01, 8'h20, 8'h00, 8'h05};
        statusQ = '{8'h00};
        expEvents = '{EV_DONE};
        c0 = wreadyCount;
        @(negedge mclk);
        waddr = 24'h012345;
        wlen = 9'd0;
        erase = 1'b1;
        @(negedge mclk);
        erase = 1'b0;
        checkOutput("erase_busy", 32'(busy), 32'd1);
        waitFinish("erase");
        endTest("erase");
        checkOutput("erase_no_wready", 32'(wreadyCount - c0), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
